// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data RAM between the fetch path and
//   the load/store path. Each cycle it grants at most one request and drives
//   the RAM port. Read data arrives one cycle later and is routed back to the
//   requester that issued it. Data wins conflicts until fetch has lost
//   STARVE_MAX conflicts in a row; the next conflict then goes to fetch.
//   if_flush drops the response of a fetch granted in the same cycle.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   if_req_valid/addr, if_req_ready  fetch request and grant
//   if_rsp_valid/data, if_flush      fetch response, response kill
//   d_req_valid/we/addr/wdata        load/store request
//   d_req_ready                      data grant
//   d_rsp_valid/data                 load data or store ack (data 0 on ack)
//   mem_en/we/addr/wdata, mem_rdata  RAM port (rdata valid cycle after read)
//   conflict_cnt                     cycles with both requests valid
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              if_flush,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       conflict_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       grant_f_s;
  logic       grant_d_s;
  logic [3:0] starve_r;
  logic       rsp_pend_r;
  logic       rsp_src_r;   // 0 = fetch, 1 = data
  logic       rsp_we_r;
  logic [31:0] conflict_cnt_r;

  // Grant selection: data wins conflicts unless fetch has starved long enough.
  always_comb begin
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    if (reset) begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (if_req_valid && d_req_valid) begin
      if (starve_r == STARVE_LIM) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
    end else if (if_req_valid) begin
      grant_f_s = 1'b1;
    end else if (d_req_valid) begin
      grant_d_s = 1'b1;
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // RAM port mux: driven by the granted requester, all zero when idle.
  always_comb begin
    if_req_ready = grant_f_s;
    d_req_ready  = grant_d_s;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case ({grant_d_s, grant_f_s})
      2'b01: begin
        mem_en   = 1'b1;
        mem_addr = if_req_addr;
      end
      2'b10: begin
        mem_en    = 1'b1;
        mem_we    = d_req_we;
        mem_addr  = d_req_addr;
        mem_wdata = d_req_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Starvation counter, conflict counter and in-flight response tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r       <= 4'd0;
      rsp_pend_r     <= 1'b0;
      rsp_src_r      <= 1'b0;
      rsp_we_r       <= 1'b0;
      conflict_cnt_r <= 32'd0;
    end else begin
      if (if_req_valid && d_req_valid) begin
        conflict_cnt_r <= conflict_cnt_r + 32'd1;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end

      if (!if_req_valid || grant_f_s) begin
        starve_r <= 4'd0;
      end else if (d_req_valid && grant_d_s && (starve_r < STARVE_LIM)) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end

      // A fetch granted alongside a flush never produces a response.
      if (grant_f_s || grant_d_s) begin
        rsp_pend_r <= grant_d_s | ~if_flush;
        rsp_src_r  <= grant_d_s;
        rsp_we_r   <= grant_d_s & d_req_we;
      end else begin
        rsp_pend_r <= 1'b0;
        rsp_src_r  <= rsp_src_r;
        rsp_we_r   <= rsp_we_r;
      end
    end
  end

  // Response routing; a pending response is also suppressed while in reset.
  always_comb begin
    if_rsp_valid = rsp_pend_r & ~rsp_src_r & ~reset;
    d_rsp_valid  = rsp_pend_r &  rsp_src_r & ~reset;
    if_rsp_data  = '0;
    d_rsp_data   = '0;
    if (if_rsp_valid) begin
      if_rsp_data = mem_rdata;
    end else begin
      if_rsp_data = '0;
    end
    if (d_rsp_valid && !rsp_we_r) begin
      d_rsp_data = mem_rdata;
    end else begin
      d_rsp_data = '0;
    end
  end

  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [11:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_flush;
  logic        d_req_valid;
  logic        d_req_we;
  logic [11:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:4095];

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_flush(if_flush),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Simple synchronous RAM; reset reloads the known preload words.
  always @(posedge clk) begin
    if (reset) begin
      ram[0]      <= 32'hE3A01005;
      ram[1]      <= 32'h11111111;
      ram[2]      <= 32'h22222222;
      ram[3]      <= 32'h33333333;
      ram[12'h020] <= 32'h20202020;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = 12'd0; if_flush = 1'b0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 12'd0; d_req_wdata = 32'd0;
  endtask

  initial begin
    logic prev_f;
    logic gf;
    reset = 1'b1;
    idle();

    // Reset with both requests valid: no grants, no RAM access.
    tick();
    if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1;
    #1;
    check("rst_if_ready", if_req_ready, 32'd0);
    check("rst_d_ready", d_req_ready, 32'd0);
    check("rst_mem_en", mem_en, 32'd0);
    check("rst_mem_we", mem_we, 32'd0);
    tick(); idle(); #1;
    check("rst_if_rsp", if_rsp_valid, 32'd0);
    check("rst_d_rsp", d_rsp_valid, 32'd0);
    check("rst_conflict", conflict_cnt, 32'd0);

    // Fetch stream 0,1,2.
    tick(); reset = 1'b0; if_req_valid = 1'b1; if_req_addr = 12'd0; #1;
    check("f0_ready", if_req_ready, 32'd1);
    check("f0_mem_en", mem_en, 32'd1);
    check("f0_mem_we", mem_we, 32'd0);
    check("f0_mem_addr", mem_addr, 32'd0);
    tick(); if_req_addr = 12'd1; #1;
    check("f1_ready", if_req_ready, 32'd1);
    check("f1_mem_addr", mem_addr, 32'd1);
    check("f1_rsp_valid", if_rsp_valid, 32'd1);
    check("f1_rsp_data", if_rsp_data, 32'hE3A01005);
    tick(); if_req_addr = 12'd2; #1;
    check("f2_rsp_valid", if_rsp_valid, 32'd1);
    check("f2_rsp_data", if_rsp_data, 32'h11111111);
    tick(); idle(); #1;
    check("f3_rsp_valid", if_rsp_valid, 32'd1);
    check("f3_rsp_data", if_rsp_data, 32'h22222222);
    check("f3_mem_en", mem_en, 32'd0);
    check("f3_mem_addr", mem_addr, 32'd0);
    tick(); #1;
    check("f4_rsp_valid", if_rsp_valid, 32'd0);
    check("f4_rsp_data", if_rsp_data, 32'd0);

    // Store then load to 0x010.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 12'h010; d_req_wdata = 32'hDEADBEEF; #1;
    check("st_ready", d_req_ready, 32'd1);
    check("st_if_ready", if_req_ready, 32'd0);
    check("st_mem_we", mem_we, 32'd1);
    check("st_mem_addr", mem_addr, 32'h010);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); d_req_we = 1'b0; d_req_wdata = 32'd0; #1;
    check("ld_mem_we", mem_we, 32'd0);
    check("st_ack_valid", d_rsp_valid, 32'd1);
    check("st_ack_data", d_rsp_data, 32'd0);
    tick(); idle(); #1;
    check("ld_rsp_valid", d_rsp_valid, 32'd1);
    check("ld_rsp_data", d_rsp_data, 32'hDEADBEEF);
    check("ld_if_rsp", if_rsp_valid, 32'd0);
    check("ld_conflict", conflict_cnt, 32'd0);

    // Ten cycles of conflict: expected grants D,D,D,D,F,D,D,D,D,F.
    prev_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if_req_valid = 1'b1; if_req_addr = 12'd3;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 12'h010;
      #1;
      gf = (i == 4) || (i == 9);
      check($sformatf("cf%0d_if_ready", i), if_req_ready, {31'd0, gf});
      check($sformatf("cf%0d_d_ready", i), d_req_ready, {31'd0, ~gf});
      if (i > 0) begin
        if (prev_f) begin
          check($sformatf("cf%0d_if_rsp", i), if_rsp_data, 32'h33333333);
          check($sformatf("cf%0d_d_rsp_v", i), d_rsp_valid, 32'd0);
        end else begin
          check($sformatf("cf%0d_d_rsp", i), d_rsp_data, 32'hDEADBEEF);
          check($sformatf("cf%0d_if_rsp_v", i), if_rsp_valid, 32'd0);
        end
      end
      prev_f = gf;
    end
    tick(); idle(); #1;
    check("cf_conflict", conflict_cnt, 32'd10);
    check("cf_last_if_rsp", if_rsp_valid, 32'd1);
    check("cf_last_d_rsp", d_rsp_valid, 32'd0);

    // Flushed fetch, then a normal fetch.
    tick(); if_req_valid = 1'b1; if_req_addr = 12'd0; if_flush = 1'b1; #1;
    check("fl_ready", if_req_ready, 32'd1);
    tick(); if_req_addr = 12'd1; if_flush = 1'b0; #1;
    check("fl_dropped_v", if_rsp_valid, 32'd0);
    check("fl_dropped_d", if_rsp_data, 32'd0);
    check("fl_next_ready", if_req_ready, 32'd1);
    tick(); idle(); #1;
    check("fl_next_v", if_rsp_valid, 32'd1);
    check("fl_next_d", if_rsp_data, 32'h11111111);
    // Flush does not affect a data response.
    tick(); d_req_valid = 1'b1; d_req_addr = 12'h010; if_flush = 1'b1; #1;
    tick(); idle(); #1;
    check("fl_data_v", d_rsp_valid, 32'd1);
    check("fl_data_d", d_rsp_data, 32'hDEADBEEF);

    // Reset while a load is pending.
    tick(); if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_addr = 12'h010; #1;
    check("rp_d_ready", d_req_ready, 32'd1);
    tick(); reset = 1'b1; #1;
    check("rp_if_ready", if_req_ready, 32'd0);
    check("rp_d_ready_rst", d_req_ready, 32'd0);
    check("rp_mem_en", mem_en, 32'd0);
    check("rp_d_rsp", d_rsp_valid, 32'd0);
    check("rp_conflict_pre", conflict_cnt, 32'd11);
    tick(); reset = 1'b0; idle(); #1;
    check("rp_d_rsp_after", d_rsp_valid, 32'd0);
    check("rp_conflict", conflict_cnt, 32'd0);

    // Starve fetch, then a store loses to fetch and is withdrawn.
    for (int i = 0; i < 4; i++) begin
      tick();
      if_req_valid = 1'b1; if_req_addr = 12'd0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 12'h010;
      #1;
      check($sformatf("cx%0d_d_ready", i), d_req_ready, 32'd1);
    end
    tick(); d_req_we = 1'b1; d_req_addr = 12'h020; d_req_wdata = 32'hCAFEF00D; #1;
    check("cx_if_ready", if_req_ready, 32'd1);
    check("cx_d_ready", d_req_ready, 32'd0);
    check("cx_mem_we", mem_we, 32'd0);
    tick(); d_req_valid = 1'b0; d_req_we = 1'b0; if_req_addr = 12'd1; #1;
    check("cx2_d_ready", d_req_ready, 32'd0);
    check("cx2_mem_we", mem_we, 32'd0);
    check("cx2_if_rsp", if_rsp_data, 32'hE3A01005);
    tick(); idle(); d_req_valid = 1'b1; d_req_addr = 12'h020; #1;
    check("cx_ld_ready", d_req_ready, 32'd1);
    tick(); idle(); #1;
    check("cx_ld_v", d_rsp_valid, 32'd1);
    check("cx_ld_data", d_rsp_data, 32'h20202020);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
